banco_registradores_pipeline: RTL and testbench
===============================================

BANCO_REGISTRADORES_PIPELINE -- requirements
Module: banco_registradores_pipeline

Interface
REQ-001 SHALL have parameter LARGURA, default 32, data width in bits.
REQ-002 SHALL have parameter NUM_REGS, default 32, register count (power of 2, >=2); AW = $clog2(NUM_REGS).
REQ-003 SHALL have parameter ZERO_FIXO, default 1, register 0 hardwired to zero when 1.
REQ-004 SHALL have parameter BYPASS, default 1, same-cycle write-to-read forwarding when 1.
REQ-005 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-006 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port habilita_escrita0  input  1  write enable, port 0.
REQ-008 SHALL have port endereco_destino0  input  AW  write address, port 0.
REQ-009 SHALL have port dado_escrita0  input  LARGURA  write data, port 0.
REQ-010 SHALL have port habilita_escrita1  input  1  write enable, port 1.
REQ-011 SHALL have port endereco_destino1  input  AW  write address, port 1.
REQ-012 SHALL have port dado_escrita1  input  LARGURA  write data, port 1.
REQ-013 SHALL have port endereco_fonte1  input  AW  read address A.
REQ-014 SHALL have port endereco_fonte2  input  AW  read address B.
REQ-015 SHALL have port dado_fonte1  output  LARGURA  read data A.
REQ-016 SHALL have port dado_fonte2  output  LARGURA  read data B.
REQ-017 SHALL have port reserva_valida  input  1  mark a destination pending (instruction issued).
REQ-018 SHALL have port endereco_reserva  input  AW  register to mark pending.
REQ-019 SHALL have port ocupado_fonte1  output  1  busy bit of endereco_fonte1.
REQ-020 SHALL have port ocupado_fonte2  output  1  busy bit of endereco_fonte2.
REQ-021 SHALL have port num_ocupados  output  AW+1  count of busy registers, registered.

Function
REQ-022 SHALL store NUM_REGS registers of LARGURA bits plus one busy bit per register.
REQ-023 SHALL write dado_escritaN to endereco_destinoN at the clock edge when habilita_escritaN=1.
REQ-024 SHALL, when both ports write the same address in one cycle, store dado_escrita1 (port 1 wins).
REQ-025 SHALL, with ZERO_FIXO=1, ignore writes and reservations to register 0; reads of 0 return 0, busy 0.
REQ-026 SHALL read combinationally: dado_fonteX = stored value of endereco_fonteX.
REQ-027 SHALL, with BYPASS=1, return the data being written this cycle when a read address matches an active write address (port 1 over port 0); ZERO_FIXO overrides bypass for address 0.
REQ-028 SHALL, with BYPASS=0, return the pre-edge stored value (new data visible next cycle).
REQ-029 SHALL set busy[endereco_reserva] at the edge when reserva_valida=1.
REQ-030 SHALL clear busy[a] at the edge when any write port writes address a.
REQ-031 SHALL, when reservation and write hit the same register in one cycle, leave busy set (reservation wins).
REQ-032 SHALL drive ocupado_fonteX = busy[endereco_fonteX] from registered state (no bypass of busy).
REQ-033 SHALL update num_ocupados one cycle after busy bits change, equal to popcount of busy vector; never exceeds NUM_REGS (or NUM_REGS-1 with ZERO_FIXO).
REQ-034 SHALL treat a reservation of an already-busy register as no change (no double count).

Reset
REQ-035 SHALL, while reset=1 at a rising edge, clear all registers to 0, all busy bits to 0, num_ocupados to 0.
REQ-036 SHALL give reset priority over simultaneous writes and reservations in the same cycle.
REQ-037 SHALL keep read outputs combinational during reset (reflect stored, i.e. zeroed, values after the edge).

Verification
REQ-038 SHALL cover: write 0xDEADBEEF to r5 via port 0, next cycle read r5 on fonte1 -> 0xDEADBEEF.
REQ-039 SHALL cover: same cycle port0 writes r7=0x11, port1 writes r7=0x22, fonte2=r7 (BYPASS=1) -> 0x22 same cycle and stored 0x22 after.
REQ-040 SHALL cover: write 0xFFFFFFFF to r0 and reserve r0 -> dado_fonte1(r0)=0, ocupado_fonte1=0, num_ocupados=0.
REQ-041 SHALL cover: reserve r3, r4 on consecutive cycles -> num_ocupados 1 then 2; write r3 -> ocupado r3=0, num_ocupados=1.
REQ-042 SHALL cover: reserve r9 and write r9 in the same cycle -> r9 holds new data, busy r9=1.
REQ-043 SHALL cover: reset asserted mid-sequence with writes pending -> after edge all reads 0, all busy 0, num_ocupados 0.

Source files
------------

// File: rtl/banco_registradores_pipeline.sv
// Register file with two write ports, two combinational read ports and a
// per-register busy scoreboard for an in-order issue pipeline.

// One storage cell: data word plus its busy bit. Address decode lives in the top.
module banco_reg_cell #(
  parameter int LARGURA = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               we0,
  input  logic [LARGURA-1:0] d0,
  input  logic               we1,
  input  logic [LARGURA-1:0] d1,
  input  logic               res,
  output logic [LARGURA-1:0] q,
  output logic               busy
);

  // Data: port 1 overrides port 0. Busy: a reservation beats a retiring write.
  always_ff @(posedge clk) begin
    if (reset) begin
      q    <= '0;
      busy <= 1'b0;
    end else begin
      if (we1)      q <= d1;
      else if (we0) q <= d0;
      if (res)             busy <= 1'b1;
      else if (we0 || we1) busy <= 1'b0;
    end
  end

endmodule

module banco_registradores_pipeline #(
  parameter int LARGURA   = 32,
  parameter int NUM_REGS  = 32,
  parameter int ZERO_FIXO = 1,
  parameter int BYPASS    = 1,
  localparam int AW       = $clog2(NUM_REGS)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               habilita_escrita0,
  input  logic [AW-1:0]      endereco_destino0,
  input  logic [LARGURA-1:0] dado_escrita0,
  input  logic               habilita_escrita1,
  input  logic [AW-1:0]      endereco_destino1,
  input  logic [LARGURA-1:0] dado_escrita1,
  input  logic [AW-1:0]      endereco_fonte1,
  input  logic [AW-1:0]      endereco_fonte2,
  output logic [LARGURA-1:0] dado_fonte1,
  output logic [LARGURA-1:0] dado_fonte2,
  input  logic               reserva_valida,
  input  logic [AW-1:0]      endereco_reserva,
  output logic               ocupado_fonte1,
  output logic               ocupado_fonte2,
  output logic [AW:0]        num_ocupados
);

  logic [NUM_REGS-1:0][LARGURA-1:0] regs_q;
  logic [NUM_REGS-1:0]              busy_q;
  logic [AW:0]                      cont;

  // Per-register decode; register 0 never sees enables when hardwired to zero,
  // so its data and busy bit stay at their reset value forever.
  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    localparam bit FIXO = (ZERO_FIXO != 0) && (i == 0);
    logic we0, we1, res;
    assign we0 = !FIXO && habilita_escrita0 && (endereco_destino0 == AW'(i));
    assign we1 = !FIXO && habilita_escrita1 && (endereco_destino1 == AW'(i));
    assign res = !FIXO && reserva_valida    && (endereco_reserva  == AW'(i));
    banco_reg_cell #(.LARGURA(LARGURA)) u_cell (
      .clk  (clk),
      .reset(reset),
      .we0  (we0),
      .d0   (dado_escrita0),
      .we1  (we1),
      .d1   (dado_escrita1),
      .res  (res),
      .q    (regs_q[i]),
      .busy (busy_q[i])
    );
  end

  // Read path: stored value, optionally forwarded from an in-flight write;
  // address 0 forced to zero last so it wins over forwarding.
  function automatic logic [LARGURA-1:0] ler(
    input logic [AW-1:0]                     a,
    input logic [NUM_REGS-1:0][LARGURA-1:0]  regs
  );
    logic [LARGURA-1:0] v;
    v = regs[a];
    if (BYPASS != 0) begin
      if (habilita_escrita1 && endereco_destino1 == a)      v = dado_escrita1;
      else if (habilita_escrita0 && endereco_destino0 == a) v = dado_escrita0;
    end
    if (ZERO_FIXO != 0 && a == '0) v = '0;
    return v;
  endfunction

  // Combinational read data for both sources.
  always_comb begin
    dado_fonte1 = ler(endereco_fonte1, regs_q);
    dado_fonte2 = ler(endereco_fonte2, regs_q);
  end

  // Busy is reported from registered state only.
  assign ocupado_fonte1 = busy_q[endereco_fonte1];
  assign ocupado_fonte2 = busy_q[endereco_fonte2];

  // Popcount of the busy vector.
  always_comb begin
    cont = '0;
    for (int i = 0; i < NUM_REGS; i++) cont = cont + {{AW{1'b0}}, busy_q[i]};
  end

  // Count is registered, so it trails the busy bits by one cycle.
  always_ff @(posedge clk) begin
    if (reset) num_ocupados <= '0;
    else       num_ocupados <= cont;
  end

endmodule

// File: tb/tb_banco_registradores_pipeline.sv
module tb_banco_registradores_pipeline;
  localparam int W  = 32;
  localparam int N  = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic          habilita_escrita0, habilita_escrita1, reserva_valida;
  logic [AW-1:0] endereco_destino0, endereco_destino1;
  logic [AW-1:0] endereco_fonte1, endereco_fonte2, endereco_reserva;
  logic [W-1:0]  dado_escrita0, dado_escrita1;
  logic [W-1:0]  dado_fonte1, dado_fonte2, nb_fonte1, nb_fonte2;
  logic          ocupado_fonte1, ocupado_fonte2, nb_ocup1, nb_ocup2;
  logic [AW:0]   num_ocupados, nb_num;

  int total = 0;
  int bad   = 0;

  // Reference model: plain arrays of values and busy flags.
  logic [W-1:0] mreg [N];
  bit           mbusy[N];
  int           mnum;

  always #5 clk = ~clk;

  banco_registradores_pipeline u_dut (
    .clk(clk), .reset(reset),
    .habilita_escrita0(habilita_escrita0), .endereco_destino0(endereco_destino0),
    .dado_escrita0(dado_escrita0),
    .habilita_escrita1(habilita_escrita1), .endereco_destino1(endereco_destino1),
    .dado_escrita1(dado_escrita1),
    .endereco_fonte1(endereco_fonte1), .endereco_fonte2(endereco_fonte2),
    .dado_fonte1(dado_fonte1), .dado_fonte2(dado_fonte2),
    .reserva_valida(reserva_valida), .endereco_reserva(endereco_reserva),
    .ocupado_fonte1(ocupado_fonte1), .ocupado_fonte2(ocupado_fonte2),
    .num_ocupados(num_ocupados)
  );

  banco_registradores_pipeline #(.BYPASS(0)) u_nb (
    .clk(clk), .reset(reset),
    .habilita_escrita0(habilita_escrita0), .endereco_destino0(endereco_destino0),
    .dado_escrita0(dado_escrita0),
    .habilita_escrita1(habilita_escrita1), .endereco_destino1(endereco_destino1),
    .dado_escrita1(dado_escrita1),
    .endereco_fonte1(endereco_fonte1), .endereco_fonte2(endereco_fonte2),
    .dado_fonte1(nb_fonte1), .dado_fonte2(nb_fonte2),
    .reserva_valida(reserva_valida), .endereco_reserva(endereco_reserva),
    .ocupado_fonte1(nb_ocup1), .ocupado_fonte2(nb_ocup2),
    .num_ocupados(nb_num)
  );

  task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] esp);
    total++;
    if (obs !== esp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h t=%0t", tag, obs, esp, $time);
    end
  endtask

  function automatic logic [W-1:0] esp_rd(input logic [AW-1:0] a, input bit byp);
    if (a == 0) return '0;
    if (byp && habilita_escrita1 && endereco_destino1 == a) return dado_escrita1;
    if (byp && habilita_escrita0 && endereco_destino0 == a) return dado_escrita0;
    return mreg[a];
  endfunction

  // Drive one cycle of inputs, let them settle, compare against the model.
  task automatic aplica(input bit rst,
                        input bit we0, input int a0, input logic [W-1:0] d0,
                        input bit we1, input int a1, input logic [W-1:0] d1,
                        input int s1, input int s2, input bit rv, input int ra);
    reset = rst;
    habilita_escrita0 = we0; endereco_destino0 = AW'(a0); dado_escrita0 = d0;
    habilita_escrita1 = we1; endereco_destino1 = AW'(a1); dado_escrita1 = d1;
    endereco_fonte1 = AW'(s1); endereco_fonte2 = AW'(s2);
    reserva_valida = rv; endereco_reserva = AW'(ra);
    #1;
    if (!rst) begin
      verifica("rd1",     dado_fonte1, esp_rd(endereco_fonte1, 1'b1));
      verifica("rd2",     dado_fonte2, esp_rd(endereco_fonte2, 1'b1));
      verifica("nb_rd1",  nb_fonte1,   esp_rd(endereco_fonte1, 1'b0));
      verifica("nb_rd2",  nb_fonte2,   esp_rd(endereco_fonte2, 1'b0));
      verifica("ocup1",   32'(ocupado_fonte1), 32'(mbusy[endereco_fonte1]));
      verifica("ocup2",   32'(ocupado_fonte2), 32'(mbusy[endereco_fonte2]));
      verifica("nb_ocup", 32'({nb_ocup1, nb_ocup2}),
               32'({mbusy[endereco_fonte1], mbusy[endereco_fonte2]}));
      verifica("num",     32'(num_ocupados), 32'(mnum));
      verifica("nb_num",  32'(nb_num),       32'(mnum));
    end
  endtask

  // Take the clock edge and advance the model by the same rules.
  task automatic avanca();
    int c;
    @(posedge clk);
    if (reset) begin
      for (int i = 0; i < N; i++) begin mreg[i] = '0; mbusy[i] = 1'b0; end
      mnum = 0;
    end else begin
      c = 0;
      for (int i = 0; i < N; i++) c += int'(mbusy[i]);
      mnum = c;
      if (habilita_escrita0 && endereco_destino0 != 0) begin
        mreg[endereco_destino0] = dado_escrita0; mbusy[endereco_destino0] = 1'b0;
      end
      if (habilita_escrita1 && endereco_destino1 != 0) begin
        mreg[endereco_destino1] = dado_escrita1; mbusy[endereco_destino1] = 1'b0;
      end
      if (reserva_valida && endereco_reserva != 0) mbusy[endereco_reserva] = 1'b1;
    end
    @(negedge clk);
  endtask

  function automatic int rnd_addr();
    return ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, N-1)) : int'($urandom_range(0, 7));
  endfunction

  initial begin
    for (int i = 0; i < N; i++) begin mreg[i] = '0; mbusy[i] = 1'b0; end
    mnum = 0;
    aplica(1, 0,0,0, 0,0,0, 0,0, 0,0); avanca();
    aplica(1, 0,0,0, 0,0,0, 0,0, 0,0); avanca();
    // post-reset state
    aplica(0, 0,0,0, 0,0,0, 1,2, 0,0);
    verifica("rst_num", 32'(num_ocupados), 32'd0);
    avanca();

    // write r5 then read it
    aplica(0, 1,5,32'hDEADBEEF, 0,0,0, 0,0, 0,0); avanca();
    aplica(0, 0,0,0, 0,0,0, 5,0, 0,0);
    verifica("r5", dado_fonte1, 32'hDEADBEEF);
    avanca();

    // both ports hit r7: port 1 wins, forwarded same cycle
    aplica(0, 1,7,32'h11, 1,7,32'h22, 0,7, 0,0);
    verifica("byp_r7", dado_fonte2, 32'h22);
    avanca();
    aplica(0, 0,0,0, 0,0,0, 0,7, 0,0);
    verifica("r7", dado_fonte2, 32'h22);
    avanca();

    // r0 stays zero and never busy
    aplica(0, 1,0,32'hFFFFFFFF, 0,0,0, 0,0, 1,0);
    verifica("r0_byp", dado_fonte1, 32'h0);
    avanca();
    aplica(0, 0,0,0, 0,0,0, 0,0, 0,0);
    verifica("r0", dado_fonte1, 32'h0);
    verifica("r0_ocup", 32'(ocupado_fonte1), 32'd0);
    avanca();
    aplica(0, 0,0,0, 0,0,0, 0,0, 0,0);
    verifica("r0_num", 32'(num_ocupados), 32'd0);
    avanca();

    // reserve r3, r4; count trails by a cycle; retire r3
    aplica(0, 0,0,0, 0,0,0, 3,4, 1,3); avanca();
    aplica(0, 0,0,0, 0,0,0, 3,4, 1,4);
    verifica("r3_ocup", 32'(ocupado_fonte1), 32'd1);
    avanca();
    aplica(0, 0,0,0, 0,0,0, 3,4, 0,0);
    verifica("num1", 32'(num_ocupados), 32'd1);
    avanca();
    aplica(0, 1,3,32'h3333, 0,0,0, 3,4, 0,0);
    verifica("num2", 32'(num_ocupados), 32'd2);
    avanca();
    aplica(0, 0,0,0, 0,0,0, 3,4, 0,0);
    verifica("r3_livre", 32'(ocupado_fonte1), 32'd0);
    avanca();
    aplica(0, 0,0,0, 0,0,0, 3,4, 0,0);
    verifica("num_ret", 32'(num_ocupados), 32'd1);
    avanca();

    // reserve and write r9 together: data lands, busy stays
    aplica(0, 1,9,32'hA5A5A5A5, 0,0,0, 9,0, 1,9); avanca();
    aplica(0, 0,0,0, 0,0,0, 9,0, 0,0);
    verifica("r9", dado_fonte1, 32'hA5A5A5A5);
    verifica("r9_ocup", 32'(ocupado_fonte1), 32'd1);
    avanca();

    // reset with a write and reservation in the same cycle
    aplica(0, 0,0,0, 0,0,0, 0,0, 1,13); avanca();
    aplica(1, 1,12,32'hCAFE, 1,14,32'hBEEF, 0,0, 1,13); avanca();
    aplica(0, 0,0,0, 0,0,0, 12,13, 0,0);
    verifica("rst_r12", dado_fonte1, 32'h0);
    verifica("rst_ocup13", 32'(ocupado_fonte2), 32'd0);
    verifica("rst_num2", 32'(num_ocupados), 32'd0);
    avanca();
    aplica(0, 0,0,0, 0,0,0, 5,7, 0,0);
    verifica("rst_r5", dado_fonte1, 32'h0);
    verifica("rst_r7", dado_fonte2, 32'h0);
    avanca();

    // randomized traffic
    for (int k = 0; k < 600; k++) begin
      aplica(($urandom_range(0, 79) == 0),
             bit'($urandom_range(0, 1)), rnd_addr(), $urandom(),
             bit'($urandom_range(0, 1)), rnd_addr(), $urandom(),
             rnd_addr(), rnd_addr(),
             ($urandom_range(0, 2) != 0), rnd_addr());
      avanca();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
